ex1_input_conditioner: RTL



---
 rtl/ex1_pkg.sv | 11 +
 rtl/ex1_debounce_ch.sv | 74 +++++++
 rtl/ex1_input_conditioner.sv | 45 ++++
 3 files changed

// File: rtl/ex1_pkg.sv
// Shared constants for the ex1 input conditioner and the board top-level.
package ex1_pkg;

    localparam int DEBOUNCE_DEFAULT = 4;

    // Counter width holding 0..debounce_cycles without wrap.
    function automatic int cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/ex1_debounce_ch.sv
// One switch channel: 2-flop synchronizer, consecutive-cycle debounce filter,
// and registered one-cycle rise/fall strobes aligned with the new stable level.
module ex1_debounce_ch
    import ex1_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             r_fall;

    logic             w_stable_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;

    // Filter next state: any agreeing cycle restarts the count.
    always_comb begin
        w_stable_nxt = r_stable;
        w_cnt_nxt    = CNT_ZERO;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        if (r_sync2 == r_stable) begin
            w_cnt_nxt = CNT_ZERO;
        end else if (r_cnt == CNT_MAX) begin
            w_stable_nxt = r_sync2;
            w_cnt_nxt    = CNT_ZERO;
            w_rise_nxt   = r_sync2;
            w_fall_nxt   = ~r_sync2;
        end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end
    end

    // Synchronizer, filter state and strobe registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= CNT_ZERO;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_sync1  <= i_sw;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
        end
    end

    assign o_level = r_stable;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ex1_input_conditioner.sv
// Two independent debounce channels producing the clean A/B levels and
// their edge strobes for ex1_block.
module ex1_input_conditioner
    import ex1_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_a,
    input  logic sw_b,
    output logic A,
    output logic B,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    ex1_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch_a (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_sw    (sw_a),
        .o_level (A),
        .o_rise  (a_rise),
        .o_fall  (a_fall)
    );

    ex1_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch_b (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_sw    (sw_b),
        .o_level (B),
        .o_rise  (b_rise),
        .o_fall  (b_fall)
    );

endmodule
